hsid_min_dist: RTL and testbench

- Consumes the per-band accumulator stream of hsid_sq_df_acc (acc_valid/acc_value/acc_last/acc_ref).
- Tracks the minimum final squared-difference distance across all library references for one pixel, then presents the best-matching reference index and its distance on a valid/ready result port.
- Sits directly downstream of hsid_sq_df_acc and feeds the classification result back to the controller/bus interface.

---
 rtl/hsid_min_dist.sv | 113 +++++++++++
 tb/tb_hsid_min_dist.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/hsid_min_dist.sv
// Minimum-distance search over the per-reference accumulator stream.
// Reports the best-matching library reference and its distance on a valid/ready port.
module hsid_min_dist #(
  parameter int  DATA_WIDTH_ACC = 32,
  parameter int  LIBRARY_SIZE   = 16,
  localparam int LIBRARY_ADDR   = $clog2(LIBRARY_SIZE)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [LIBRARY_ADDR:0]     library_size,
  input  logic                      acc_valid,
  input  logic [DATA_WIDTH_ACC-1:0] acc_value,
  input  logic                      acc_last,
  input  logic [LIBRARY_ADDR-1:0]   acc_ref,
  output logic                      busy,
  output logic                      result_valid,
  input  logic                      result_ready,
  output logic [LIBRARY_ADDR-1:0]   result_ref,
  output logic [DATA_WIDTH_ACC-1:0] result_dist,
  output logic [LIBRARY_ADDR:0]     result_count
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [LIBRARY_ADDR:0]     size_q, size_d;
  logic [LIBRARY_ADDR:0]     count_q, count_d;
  logic [DATA_WIDTH_ACC-1:0] min_q, min_d;
  logic [LIBRARY_ADDR-1:0]   min_ref_q, min_ref_d;
  logic [LIBRARY_ADDR-1:0]   res_ref_q, res_ref_d;
  logic [DATA_WIDTH_ACC-1:0] res_dist_q, res_dist_d;
  logic [LIBRARY_ADDR:0]     res_count_q, res_count_d;

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    count_d     = count_q;
    min_d       = min_q;
    min_ref_d   = min_ref_q;
    res_ref_d   = res_ref_q;
    res_dist_d  = res_dist_q;
    res_count_d = res_count_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          size_d      = library_size;
          count_d     = '0;
          min_d       = '1;
          min_ref_d   = '0;
          res_ref_d   = '0;
          res_dist_d  = '1;
          res_count_d = '0;
          state_d     = (library_size == '0) ? ST_DONE : ST_RUN;
        end
      end
      ST_RUN: begin
        if (acc_valid && acc_last) begin
          count_d = count_q + (LIBRARY_ADDR+1)'(1);
          // Strict compare: ties and all-ones values keep the earlier reference.
          if (acc_value < min_q) begin
            min_d     = acc_value;
            min_ref_d = acc_ref;
          end
          if (count_d == size_q) begin
            state_d     = ST_DONE;
            res_ref_d   = min_ref_d;
            res_dist_d  = min_d;
            res_count_d = count_d;
          end
        end
      end
      ST_DONE: begin
        if (result_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      size_q      <= '0;
      count_q     <= '0;
      min_q       <= '1;
      min_ref_q   <= '0;
      res_ref_q   <= '0;
      res_dist_q  <= '1;
      res_count_q <= '0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      count_q     <= count_d;
      min_q       <= min_d;
      min_ref_q   <= min_ref_d;
      res_ref_q   <= res_ref_d;
      res_dist_q  <= res_dist_d;
      res_count_q <= res_count_d;
    end
  end

  assign busy         = (state_q == ST_RUN);
  assign result_valid = (state_q == ST_DONE);
  assign result_ref   = res_ref_q;
  assign result_dist  = res_dist_q;
  assign result_count = res_count_q;

endmodule

// File: tb/tb_hsid_min_dist.sv
// Directed bench for hsid_min_dist with hand-computed expectations.
module tb_hsid_min_dist;
  localparam int DW = 32;
  localparam int LS = 16;
  localparam int AW = 4;
  localparam logic [DW-1:0] ONES = '1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [AW:0]   library_size = '0;
  logic          acc_valid = 1'b0;
  logic [DW-1:0] acc_value = '0;
  logic          acc_last = 1'b0;
  logic [AW-1:0] acc_ref = '0;
  logic          busy, result_valid;
  logic          result_ready = 1'b0;
  logic [AW-1:0] result_ref;
  logic [DW-1:0] result_dist;
  logic [AW:0]   result_count;

  int n_checks = 0;
  int n_fail   = 0;

  hsid_min_dist #(.DATA_WIDTH_ACC(DW), .LIBRARY_SIZE(LS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .library_size(library_size),
    .acc_valid(acc_valid), .acc_value(acc_value), .acc_last(acc_last), .acc_ref(acc_ref),
    .busy(busy), .result_valid(result_valid), .result_ready(result_ready),
    .result_ref(result_ref), .result_dist(result_dist), .result_count(result_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int size);
    start = 1'b1;
    library_size = (AW+1)'(size);
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input int r, input logic [DW-1:0] v, input logic last);
    acc_valid = 1'b1;
    acc_ref   = AW'(r);
    acc_value = v;
    acc_last  = last;
    tick();
    acc_valid = 1'b0;
    acc_last  = 1'b0;
  endtask

  task automatic check_result(input string tag, input int r, input logic [DW-1:0] d, input int c);
    check({tag, "_valid"}, 64'(result_valid), 64'd1);
    check({tag, "_busy"},  64'(busy),         64'd0);
    check({tag, "_ref"},   64'(result_ref),   64'(r));
    check({tag, "_dist"},  64'(result_dist),  64'(d));
    check({tag, "_count"}, 64'(result_count), 64'(c));
  endtask

  task automatic handshake(input string tag);
    result_ready = 1'b1;
    tick();
    result_ready = 1'b0;
    check({tag, "_hs_valid"}, 64'(result_valid), 64'd0);
  endtask

  initial begin
    // reset state
    tick();
    check("rst_busy",  64'(busy),         64'd0);
    check("rst_valid", 64'(result_valid), 64'd0);
    check("rst_ref",   64'(result_ref),   64'd0);
    check("rst_dist",  64'(result_dist),  64'(ONES));
    check("rst_count", 64'(result_count), 64'd0);
    rst_n = 1'b1;
    tick();

    // basic search, back-to-back last beats
    do_start(3);
    check("t1_busy", 64'(busy), 64'd1);
    beat(0, 32'd500, 1'b1);
    check("t1_run_valid", 64'(result_valid), 64'd0);
    beat(1, 32'd120, 1'b1);
    beat(2, 32'd300, 1'b1);
    check_result("t1", 1, 32'd120, 3);
    // start coincident with handshake is ignored
    start = 1'b1;
    library_size = 5'd2;
    handshake("t1");
    start = 1'b0;
    check("t1_idle_busy", 64'(busy), 64'd0);
    check("t1_hold_ref",  64'(result_ref),  64'd1);
    check("t1_hold_dist", 64'(result_dist), 64'd120);
    tick();
    check("t1_still_idle", 64'(busy), 64'd0);

    // tie keeps earlier reference
    do_start(2);
    beat(0, 32'd77, 1'b1);
    beat(1, 32'd77, 1'b1);
    check_result("t2", 0, 32'd77, 2);
    handshake("t2");

    // non-last beats ignored, backpressure holds result
    do_start(2);
    beat(0, 32'd900, 1'b1);
    beat(3, 32'd5, 1'b0);
    beat(2, 32'd5, 1'b0);
    beat(1, 32'd800, 1'b1);
    for (int i = 0; i < 10; i++) begin
      check("t3_stall_valid", 64'(result_valid), 64'd1);
      check("t3_stall_ref",   64'(result_ref),   64'd1);
      check("t3_stall_dist",  64'(result_dist),  64'd800);
      tick();
    end
    check_result("t3", 1, 32'd800, 2);
    handshake("t3");
    check("t3_idle_busy", 64'(busy), 64'd0);

    // zero-size library
    do_start(0);
    check_result("t4", 0, ONES, 0);
    handshake("t4");

    // extra last beat after completion is ignored
    do_start(2);
    beat(0, 32'd50, 1'b1);
    beat(1, 32'd60, 1'b1);
    beat(2, 32'd10, 1'b1);
    check_result("t5", 0, 32'd50, 2);
    handshake("t5");

    // all-ones distances never replace the initial minimum
    do_start(2);
    beat(3, ONES, 1'b1);
    beat(5, ONES, 1'b1);
    check_result("t6", 0, ONES, 2);
    handshake("t6");

    // reset mid-search
    do_start(3);
    beat(0, 32'd30, 1'b1);
    check("t7_busy_pre", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check("t7_rst_busy",  64'(busy),         64'd0);
    check("t7_rst_valid", 64'(result_valid), 64'd0);
    check("t7_rst_ref",   64'(result_ref),   64'd0);
    check("t7_rst_dist",  64'(result_dist),  64'(ONES));
    check("t7_rst_count", 64'(result_count), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    check("t7_post_busy", 64'(busy), 64'd0);
    do_start(1);
    beat(0, 32'd42, 1'b1);
    check_result("t7", 0, 32'd42, 1);
    handshake("t7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
